// File: rtl/hzdunit_pipe.sv
// Hazard unit for the 5-stage core: load-use bubbles, memory-busy freeze, branch flush, EX forwarding.
// Optional stall statistics counter (stall_cnt port) enabled by defining HZD_STATS_EN.
module hzdunit_pipe #(
  parameter int OPC_W        = 6,
  parameter int REG_W        = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int STAT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OPC_W+2*REG_W-1:0] id_instr,
  input  logic                     ex_memtoreg,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic                     ex_branch_tk,
  input  logic                     mem_regwrite,
  input  logic [REG_W-1:0]         mem_rd,
  input  logic                     wb_regwrite,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic [REG_W-1:0]         ex_rs,
  input  logic [REG_W-1:0]         ex_rt,
  input  logic                     mem_busy,
  output logic                     stall_pc,
  output logic                     stall_id,
  output logic                     freeze,
  output logic                     flush_id,
  output logic                     bubble_ex,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b
`ifdef HZD_STATS_EN
  ,
  output logic [STAT_W-1:0]        stall_cnt
`endif
);

  // state     | meaning
  // S_RUN     | normal issue; load-use hazard checked every cycle
  // S_LDSTALL | inserting the remaining bubbles of a multi-bubble load-use stall

  localparam int INSTR_W = OPC_W + 2*REG_W;
  localparam logic [OPC_W-1:0] OP_J   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_JAL = OPC_W'(3);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 15 || STAT_W < 1) begin : g_param_check
    $error("hzdunit_pipe: LOAD_BUBBLES must be 1..15 and STAT_W at least 1");
  end

  typedef enum logic {S_RUN, S_LDSTALL} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OPC_W-1:0]   id_opc;
  logic [REG_W-1:0]   id_rs, id_rt;
  logic               ld_hazard;
  logic               stall_c, freeze_c, flush_c, bubble_c;
  logic [1:0]         fwd_a_c, fwd_b_c;

  assign id_opc = id_instr[INSTR_W-1 -: OPC_W];
  assign id_rs  = id_instr[2*REG_W-1 -: REG_W];
  assign id_rt  = id_instr[REG_W-1:0];

  // Jumps carry a target field where rs/rt would be, so they never read registers.
  assign ld_hazard = ex_memtoreg && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt)) &&
                     (id_opc != OP_J) && (id_opc != OP_JAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    freeze_c = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    if (mem_busy) begin
      stall_c  = 1'b1;
      freeze_c = 1'b1;
    end else if (ex_branch_tk) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      state_d  = S_RUN;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ld_hazard) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = S_LDSTALL;
              cnt_d   = 4'(LOAD_BUBBLES - 1);
            end
          end
        end
        S_LDSTALL: begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // MEM/WB results are newer than the regfile; EX/MEM is newer than MEM/WB.
  always_comb begin
    fwd_a_c = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
      fwd_a_c = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
      fwd_a_c = 2'b01;
  end

  always_comb begin
    fwd_b_c = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt))
      fwd_b_c = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt))
      fwd_b_c = 2'b01;
  end

  // Outputs are forced low for the whole reset window, not just after a clock edge.
  assign stall_pc  = rst_n & stall_c;
  assign stall_id  = rst_n & stall_c;
  assign freeze    = rst_n & freeze_c;
  assign flush_id  = rst_n & flush_c;
  assign bubble_ex = rst_n & bubble_c;
  assign fwd_a     = rst_n ? fwd_a_c : 2'b00;
  assign fwd_b     = rst_n ? fwd_b_c : 2'b00;

`ifdef HZD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_pc && (stall_cnt != {STAT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hzdunit_pipe.sv
// Bench for hzdunit_pipe: two instances (1 and 3 load bubbles) on shared stimulus,
// directed scenarios plus a randomized run against a stall-debt reference model.
module tb_hzdunit_pipe;
  localparam int STAT_W = 4;
  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LW  = 6'h23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id_instr;
  logic        ex_memtoreg, ex_branch_tk, mem_regwrite, wb_regwrite, mem_busy;
  logic [4:0]  ex_rd, mem_rd, wb_rd, ex_rs, ex_rt;

  logic a_stall_pc, a_stall_id, a_freeze, a_flush_id, a_bubble_ex;
  logic b_stall_pc, b_stall_id, b_freeze, b_flush_id, b_bubble_ex;
  logic [1:0] a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
`ifdef HZD_STATS_EN
  logic [STAT_W-1:0] a_stall_cnt, b_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hzdunit_pipe #(.OPC_W(6), .REG_W(5), .LOAD_BUBBLES(1), .STAT_W(STAT_W)) u_a (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd),
    .ex_branch_tk(ex_branch_tk), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_busy(mem_busy),
    .stall_pc(a_stall_pc), .stall_id(a_stall_id), .freeze(a_freeze), .flush_id(a_flush_id),
    .bubble_ex(a_bubble_ex), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b)
`ifdef HZD_STATS_EN
    , .stall_cnt(a_stall_cnt)
`endif
  );

  hzdunit_pipe #(.OPC_W(6), .REG_W(5), .LOAD_BUBBLES(3), .STAT_W(STAT_W)) u_b (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd),
    .ex_branch_tk(ex_branch_tk), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_busy(mem_busy),
    .stall_pc(b_stall_pc), .stall_id(b_stall_id), .freeze(b_freeze), .flush_id(b_flush_id),
    .bubble_ex(b_bubble_ex), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b)
`ifdef HZD_STATS_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );

  function automatic logic [15:0] mk(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt);
    return {opc, rs, rt};
  endfunction

  task automatic idle();
    id_instr = mk(OP_ADD, 5'd0, 5'd0);
    ex_memtoreg = 0; ex_rd = 0; ex_branch_tk = 0;
    mem_regwrite = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;
    ex_rs = 0; ex_rt = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    mem_busy = 1; mem_regwrite = 1; mem_rd = 7; ex_rs = 7; ex_rt = 7;
    #1;
    total++;
    if ({a_stall_pc, a_stall_id, a_freeze, a_flush_id, a_bubble_ex, a_fwd_a, a_fwd_b} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs_a: got %b want 0", {a_stall_pc, a_stall_id, a_freeze, a_flush_id, a_bubble_ex, a_fwd_a, a_fwd_b});
    end
    total++;
    if ({b_stall_pc, b_stall_id, b_freeze, b_flush_id, b_bubble_ex, b_fwd_a, b_fwd_b} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs_b: got %b want 0", {b_stall_pc, b_stall_id, b_freeze, b_flush_id, b_bubble_ex, b_fwd_a, b_fwd_b});
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ex_memtoreg = 1; ex_rd = 3; id_instr = mk(OP_ADD, 5'd3, 5'd1);
    #1;
    total++;
    if ({a_stall_pc, a_stall_id, a_bubble_ex, a_freeze} !== 4'b1110) begin
      bad++; $display("FAIL load_use_hit: got %b want 1110", {a_stall_pc, a_stall_id, a_bubble_ex, a_freeze});
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if ({a_stall_pc, a_stall_id, a_bubble_ex} !== 3'b000) begin
      bad++; $display("FAIL load_use_release: got %b want 000", {a_stall_pc, a_stall_id, a_bubble_ex});
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    @(negedge clk);
    ex_memtoreg = 1; ex_rd = 3; id_instr = mk(OP_J, 5'd3, 5'd3);
    #1;
    total++;
    if ({a_stall_pc, b_stall_pc} !== 2'b00) begin
      bad++; $display("FAIL no_hazard_j: got %b want 00", {a_stall_pc, b_stall_pc});
    end
    @(negedge clk);
    id_instr = mk(OP_JAL, 5'd3, 5'd0);
    #1;
    total++;
    if ({a_stall_pc, b_stall_pc} !== 2'b00) begin
      bad++; $display("FAIL no_hazard_jal: got %b want 00", {a_stall_pc, b_stall_pc});
    end
    @(negedge clk);
    ex_rd = 0; id_instr = mk(OP_ADD, 5'd0, 5'd0);
    #1;
    total++;
    if ({a_stall_pc, b_stall_pc} !== 2'b00) begin
      bad++; $display("FAIL no_hazard_r0: got %b want 00", {a_stall_pc, b_stall_pc});
    end
    @(negedge clk);
    ex_rd = 5; id_instr = mk(OP_LW, 5'd1, 5'd5);
    #1;
    total++;
    if ({a_stall_pc, a_bubble_ex} !== 2'b11) begin
      bad++; $display("FAIL hazard_on_rt: got %b want 11", {a_stall_pc, a_bubble_ex});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_multi_bubble();
    bit busy_pat  [5] = '{0, 0, 1, 0, 0};
    bit exp_stall [5] = '{1, 1, 1, 1, 0};
    bit exp_bub   [5] = '{1, 1, 0, 1, 0};
    int n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      // hazard stays visible in ID while stalled; LDSTALL must not restart the count
      if (i < 4) begin ex_memtoreg = 1; ex_rd = 3; id_instr = mk(OP_ADD, 5'd3, 5'd0); end
      mem_busy = busy_pat[i];
      #1;
      total++;
      if ({b_stall_pc, b_stall_id, b_bubble_ex, b_freeze} !== {exp_stall[i], exp_stall[i], exp_bub[i], busy_pat[i]}) begin
        bad++; $display("FAIL multi_bubble_cyc%0d: got %b want %b", i, {b_stall_pc, b_stall_id, b_bubble_ex, b_freeze},
                        {exp_stall[i], exp_stall[i], exp_bub[i], busy_pat[i]});
      end
      n += int'(b_stall_pc);
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL multi_bubble_count: got %0d want 4", n);
    end
    idle();
  endtask

  task automatic test_branch_flush();
    do_reset();
    @(negedge clk);
    ex_memtoreg = 1; ex_rd = 4; id_instr = mk(OP_ADD, 5'd2, 5'd4);
    @(negedge clk);
    idle();
    ex_branch_tk = 1;
    #1;
    total++;
    if ({b_flush_id, b_bubble_ex, b_stall_pc, b_stall_id, b_freeze} !== 5'b11000) begin
      bad++; $display("FAIL branch_in_ldstall: got %b want 11000", {b_flush_id, b_bubble_ex, b_stall_pc, b_stall_id, b_freeze});
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if ({b_flush_id, b_bubble_ex, b_stall_pc} !== 3'b000) begin
      bad++; $display("FAIL branch_back_to_run: got %b want 000", {b_flush_id, b_bubble_ex, b_stall_pc});
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    @(negedge clk);
    mem_regwrite = 1; wb_regwrite = 1; mem_rd = 7; wb_rd = 7; ex_rs = 7; ex_rt = 9;
    #1;
    total++;
    if ({a_fwd_a, a_fwd_b} !== 4'b1000) begin
      bad++; $display("FAIL fwd_mem_wins: got %b want 1000", {a_fwd_a, a_fwd_b});
    end
    mem_regwrite = 0;
    #1;
    total++;
    if ({a_fwd_a, b_fwd_a} !== 4'b0101) begin
      bad++; $display("FAIL fwd_from_wb: got %b want 0101", {a_fwd_a, b_fwd_a});
    end
    mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0;
    #1;
    total++;
    if (a_fwd_a !== 2'b00) begin
      bad++; $display("FAIL fwd_r0: got %b want 00", a_fwd_a);
    end
    mem_rd = 9; wb_rd = 9; ex_rs = 3;
    #1;
    total++;
    if ({a_fwd_a, a_fwd_b} !== 4'b0010) begin
      bad++; $display("FAIL fwd_b_mem: got %b want 0010", {a_fwd_a, a_fwd_b});
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk);
    ex_memtoreg = 1; ex_rd = 6; id_instr = mk(OP_ADD, 5'd6, 5'd6);
    @(negedge clk);
    idle();
    #1;
    total++;
    if (b_stall_pc !== 1'b1) begin
      bad++; $display("FAIL mid_stall_setup: got %b want 1", b_stall_pc);
    end
    mem_busy = 1;
    rst_n = 0;
    #1;
    total++;
    if ({b_stall_pc, b_stall_id, b_freeze, b_flush_id, b_bubble_ex} !== 5'd0) begin
      bad++; $display("FAIL mid_stall_reset: got %b want 0", {b_stall_pc, b_stall_id, b_freeze, b_flush_id, b_bubble_ex});
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({b_stall_pc, b_bubble_ex} !== 2'b00) begin
        bad++; $display("FAIL residual_stall_cyc%0d: got %b want 00", i, {b_stall_pc, b_bubble_ex});
      end
      @(negedge clk);
    end
  endtask

`ifdef HZD_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    total++;
    if (a_stall_cnt !== '0) begin
      bad++; $display("FAIL stats_reset: got %0d want 0", a_stall_cnt);
    end
    @(negedge clk);
    mem_busy = 1;
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (a_stall_cnt !== STAT_W'(10)) begin
      bad++; $display("FAIL stats_count: got %0d want 10", a_stall_cnt);
    end
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (b_stall_cnt !== {STAT_W{1'b1}}) begin
      bad++; $display("FAIL stats_saturate: got %0d want %0d", b_stall_cnt, (1 << STAT_W) - 1);
    end
    idle();
  endtask
`endif

  // Model: a debt of bubbles still owed after the current cycle; busy cycles neither pay nor add.
  task automatic test_random();
    int rem [2] = '{0, 0};
    int stat [2] = '{0, 0};
    int lb [2] = '{1, 3};
    logic [8:0] obs, exp;
    logic [5:0] opc;
    logic [4:0] rs, rt;
    logic hz, e_stall, e_freeze, e_flush, e_bub;
    logic [1:0] fa, fb;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: opc = OP_ADD;
        1: opc = OP_J;
        2: opc = OP_JAL;
        default: opc = OP_LW;
      endcase
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      id_instr = mk(opc, rs, rt);
      ex_memtoreg = ($urandom_range(0, 1) == 1);
      ex_rd = 5'($urandom_range(0, 3));
      ex_branch_tk = ($urandom_range(0, 9) < 2);
      mem_busy = ($urandom_range(0, 9) < 2);
      mem_regwrite = ($urandom_range(0, 1) == 1); mem_rd = 5'($urandom_range(0, 3));
      wb_regwrite = ($urandom_range(0, 1) == 1);  wb_rd = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      #1;
      hz = ex_memtoreg && ex_rd != 0 && (ex_rd == rs || ex_rd == rt) && opc != OP_J && opc != OP_JAL;
      fa = (mem_regwrite && mem_rd != 0 && mem_rd == ex_rs) ? 2'b10 :
           (wb_regwrite && wb_rd != 0 && wb_rd == ex_rs) ? 2'b01 : 2'b00;
      fb = (mem_regwrite && mem_rd != 0 && mem_rd == ex_rt) ? 2'b10 :
           (wb_regwrite && wb_rd != 0 && wb_rd == ex_rt) ? 2'b01 : 2'b00;
      for (int k = 0; k < 2; k++) begin
        e_stall = 0; e_freeze = 0; e_flush = 0; e_bub = 0;
        if (mem_busy) begin
          e_stall = 1; e_freeze = 1;
        end else if (ex_branch_tk) begin
          e_flush = 1; e_bub = 1; rem[k] = 0;
        end else if (rem[k] > 0) begin
          e_stall = 1; e_bub = 1; rem[k]--;
        end else if (hz) begin
          e_stall = 1; e_bub = 1; rem[k] = lb[k] - 1;
        end
        exp = {e_stall, e_stall, e_freeze, e_flush, e_bub, fa, fb};
        obs = (k == 0) ? {a_stall_pc, a_stall_id, a_freeze, a_flush_id, a_bubble_ex, a_fwd_a, a_fwd_b}
                       : {b_stall_pc, b_stall_id, b_freeze, b_flush_id, b_bubble_ex, b_fwd_a, b_fwd_b};
        total++;
        if (obs !== exp) begin
          bad++;
          if (bad < 20) $display("FAIL random_lb%0d_cyc%0d: got %b want %b", lb[k], cyc, obs, exp);
        end
`ifdef HZD_STATS_EN
        total++;
        if (((k == 0) ? a_stall_cnt : b_stall_cnt) !== STAT_W'(stat[k])) begin
          bad++;
          if (bad < 20) $display("FAIL random_stats_lb%0d_cyc%0d: got %0d want %0d", lb[k], cyc,
                                 (k == 0) ? a_stall_cnt : b_stall_cnt, stat[k]);
        end
`endif
        if (e_stall && stat[k] < (1 << STAT_W) - 1) stat[k]++;
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multi_bubble();
    test_branch_flush();
    test_forwarding();
    test_reset_mid_stall();
`ifdef HZD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
